result_drain: RTL
=================

Name: result_drain

Overview:
- Downstream consumer of the 8x8 matrix-vector multiplier.
- Captures the eight 24-bit accumulator results (Cout0..Cout7) once per computation, on the rising edge of the multiplier's done indication.
- Serialises the captured results as a byte stream over a valid/ready handshake, followed by an optional 8-bit checksum byte.
- Feeds the host/UART/display side of the design, so the multiplier never waits on the output path.

Parameters:
- DATA_W, 24, width of each result; must be a multiple of 8.
- NUM_RES, 8, number of results captured per computation.
- SEND_CHECKSUM, 1, when 1 a checksum byte is appended after the last data byte.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- done  input  1  multiplier completion level; high while the multiplier is in DONE.
- Cout0..Cout7  input  DATA_W each  multiplier results; valid whenever done=1.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  downstream accepts a byte this cycle.
- busy  output  1  high from capture until the final byte is accepted.
- overrun  output  1  sticky; a new computation completed while a drain was still in progress.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - out_valid=0, out_data=0, busy=0, overrun=0.
  - done_q=0, byte counter=0, checksum accumulator=0, capture registers=0.
  - State returns to IDLE.
- Edge detect: register done_q; capture_evt = done & ~done_q.
- States and transitions:
  - IDLE: on capture_evt, latch all NUM_RES results into internal registers, clear the checksum, set byte index=0, go to SEND. Next cycle out_valid=1, busy=1, out_data = first byte. Latency from capture_evt to first out_valid is 1 cycle.
  - SEND: byte order is result 0 first; within each result, MSB byte first (big-endian). A transfer occurs when out_valid & out_ready; the next byte is presented in the following cycle.
    - With out_ready held high, one byte per cycle and no bubbles.
    - Each transferred byte is added to the checksum modulo 256.
    - After byte NUM_RES*DATA_W/8 - 1 (byte 23 at defaults) transfers, go to CSUM if SEND_CHECKSUM=1, else IDLE.
  - CSUM: out_data = sum of all data bytes mod 256, out_valid=1. On transfer, go to IDLE.
  - Returning to IDLE: out_valid and busy deassert in the cycle after the last transfer.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - out_valid never drops without a transfer, except on reset.
  - out_valid never depends combinationally on out_ready.
- Simultaneous / boundary conditions:
  - capture_evt while busy: the event is ignored, captured data is unaltered, the stream continues unchanged, and overrun is set to 1 until reset.
  - done held high for many cycles: exactly one capture.
  - capture_evt in the same cycle as the final transfer (returning to IDLE): treated as busy, so overrun is set and there is no capture.
  - Inputs Cout* are sampled only on capture_evt; later changes have no effect on the stream.
  - Reset mid-stream: the stream is abandoned, no partial checksum is sent, and the next capture_evt restarts from byte 0.
- Totals: 24 data bytes + 1 checksum byte = 25 transfers at defaults.

Test Plan:
- Cout0=24'h123456, Cout1..7=0, single done pulse, out_ready=1 -> out_valid rises 1 cycle after the done edge; bytes 12,34,56 then 21x 00, then checksum 9C; 25 consecutive transfers; busy falls the cycle after.
- All Cout=24'hFFFFFF, out_ready=1 -> 24x FF then checksum E8; no bubbles.
- Cout_i = {i,i,i} (e.g., Cout3=24'h030303), out_ready toggling 1,0,0,1,... -> out_data/out_valid hold through stalls; byte sequence 00x3, 01x3 ... 07x3, checksum 0x54 (3*(0+1+...+7)=84).
- Second done edge after 5 transfers -> overrun=1 and stays 1; remaining stream identical to the first capture; no second stream afterwards.
- rst asserted after 10 transfers -> out_valid=0 and busy=0 immediately; overrun=0; new done edge with Cout0=24'hABCDEF -> stream restarts with AB, CD, EF.
- done held high for 100 cycles, out_ready=1 -> exactly 25 transfers, then out_valid stays 0; overrun stays 0.

Source files
------------

// File: rtl/result_drain.sv
// result_drain: captures the eight multiplier results on the rising edge of
// done and streams them out as bytes over a valid/ready handshake. Results go
// in order 0..NUM_RES-1, MSB byte first, with an optional mod-256 checksum
// byte at the end.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   done         multiplier completion level
//   Cout0..Cout7 multiplier results, sampled only on the done rising edge
//   out_data     stream byte (registered)
//   out_valid    out_data holds a valid byte (registered)
//   out_ready    downstream accepts a byte this cycle
//   busy         high from capture until the final byte is accepted
//   overrun      sticky: a new result arrived while a drain was in progress
module result_drain #(
  parameter int unsigned DATA_W        = 24,
  parameter int unsigned NUM_RES       = 8,
  parameter int unsigned SEND_CHECKSUM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] Cout0,
  input  logic [DATA_W-1:0] Cout1,
  input  logic [DATA_W-1:0] Cout2,
  input  logic [DATA_W-1:0] Cout3,
  input  logic [DATA_W-1:0] Cout4,
  input  logic [DATA_W-1:0] Cout5,
  input  logic [DATA_W-1:0] Cout6,
  input  logic [DATA_W-1:0] Cout7,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned BYTES_PER_RES = DATA_W / 8;
  localparam int unsigned TOTAL_BYTES   = NUM_RES * BYTES_PER_RES;
  localparam int unsigned FLAT_W        = NUM_RES * DATA_W;
  localparam int unsigned IDX_W         = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_CSUM
  } state_t;

  state_t            r_state;
  logic              r_done_q;
  logic [FLAT_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_csum;
  logic [7:0]        r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_overrun;

  logic [DATA_W-1:0] w_cout [8];
  logic [FLAT_W-1:0] w_flat;
  logic              w_cap_evt;
  logic              w_xfer;
  logic              w_last;
  logic [7:0]        w_csum_next;

  assign w_cout[0] = Cout0;
  assign w_cout[1] = Cout1;
  assign w_cout[2] = Cout2;
  assign w_cout[3] = Cout3;
  assign w_cout[4] = Cout4;
  assign w_cout[5] = Cout5;
  assign w_cout[6] = Cout6;
  assign w_cout[7] = Cout7;

  // Flatten results so result 0 sits in the top bits: the stream is then
  // simply this vector read MSB byte first.
  for (genvar g = 0; g < NUM_RES; g++) begin : g_flat
    assign w_flat[FLAT_W-1-g*DATA_W -: DATA_W] = w_cout[g];
  end

  assign w_cap_evt   = done & ~r_done_q;
  assign w_xfer      = r_out_valid & out_ready;
  assign w_last      = (r_idx == IDX_W'(TOTAL_BYTES - 1));
  assign w_csum_next = r_csum + r_out_data;

  // Capture / serialise FSM. r_shift holds the bytes still to be presented;
  // r_out_data holds the byte currently on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_done_q    <= 1'b0;
      r_shift     <= '0;
      r_idx       <= '0;
      r_csum      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done_q <= done;

      // Any edge outside IDLE (including the final-transfer cycle) is dropped.
      if (w_cap_evt && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_cap_evt) begin
            r_out_data  <= w_flat[FLAT_W-1 -: 8];
            r_shift     <= {w_flat[FLAT_W-9:0], 8'h00};
            r_idx       <= '0;
            r_csum      <= '0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_SEND;
          end
        end

        S_SEND: begin
          if (w_xfer) begin
            r_csum <= w_csum_next;
            if (w_last) begin
              if (SEND_CHECKSUM != 0) begin
                r_out_data <= w_csum_next;
                r_state    <= S_CSUM;
              end else begin
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
                r_state     <= S_IDLE;
              end
            end else begin
              r_out_data <= r_shift[FLAT_W-1 -: 8];
              r_shift    <= {r_shift[FLAT_W-9:0], 8'h00};
              r_idx      <= r_idx + IDX_W'(1);
            end
          end
        end

        S_CSUM: begin
          if (w_xfer) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule
